// File: rtl/arm_core_pkg.sv
// arm_core_pkg: shared widths, register indices and types for the ARMv8 core
package arm_core_pkg;
   localparam int XLEN = 64;
   localparam int REG_ADDR_W = 5;
   localparam logic [4:0] XZR_IDX = 5'd31;
   localparam int NUM_GPR = 32;
   typedef logic [4:0] reg_idx_t;
endpackage

// File: rtl/reg_write_decoder.sv
// reg_write_decoder: enabled one-hot write demux; the zero-register bit never fires
module reg_write_decoder #(
   parameter int ADDR_W = 5,
   parameter int ZERO_IDX = 31
) (
   input  logic                 en,
   input  logic [ADDR_W-1:0]    addr,
   output logic [2**ADDR_W-1:0] onehot
);
   // en gates every bit first, so an unknown addr cannot leak through when idle
   for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_bit
      if (i == ZERO_IDX) begin : g_z
         assign onehot[i] = 1'b0;
      end else begin : g_r
         assign onehot[i] = en && (addr == ADDR_W'(i));
      end
   end
endmodule

// File: rtl/arm_reg_file.sv
// arm_reg_file: 31x64 GPR storage plus XZR, two combinational read ports with WB->ID bypass
module arm_reg_file
   import arm_core_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int ZERO_IDX = int'(XZR_IDX),
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] RA1,
   input  logic [ADDR_W-1:0] RA2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WA,
   input  logic [DATA_W-1:0] WD
);
   localparam int N = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZI = ADDR_W'(ZERO_IDX);
   logic [N-1:0] we;
   logic [DATA_W-1:0] mem [N];
   reg_write_decoder #(.ADDR_W(ADDR_W), .ZERO_IDX(ZERO_IDX)) u_dec (
      .en(RegWrite),
      .addr(WA),
      .onehot(we)
   );
   for (genvar i = 0; i < N; i++) begin : g_ent
      if (i == ZERO_IDX) begin : g_z
         logic unused_we;
         assign unused_we = we[i];
         assign mem[i] = '0;
      end else begin : g_r
         logic [DATA_W-1:0] q;
         always_ff @(posedge clk or posedge reset)
            if (reset) q <= '0;
            else if (we[i]) q <= WD;
         assign mem[i] = q;
      end
   end
   // XZR beats bypass; reset forces zero so an in-flight WD cannot bypass during reset
   always_comb begin
      RD1 = (reset || RA1 == ZI) ? '0 : (BYPASS && RegWrite && WA == RA1) ? WD : mem[RA1];
      RD2 = (reset || RA2 == ZI) ? '0 : (BYPASS && RegWrite && WA == RA2) ? WD : mem[RA2];
   end
endmodule

// File: tb/tb_arm_reg_file.sv
// tb_arm_reg_file: randomized + directed check of both bypass variants against an array model
module tb_arm_reg_file;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic RegWrite = 1'b0;
   logic [4:0] RA1 = '0, RA2 = '0, WA = '0;
   logic [63:0] WD = '0;
   logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic [63:0] model [32];
   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   arm_reg_file #(.BYPASS(1'b1)) dut (
      .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2), .RD1(rd1_b), .RD2(rd2_b),
      .RegWrite(RegWrite), .WA(WA), .WD(WD)
   );
   arm_reg_file #(.BYPASS(1'b0)) dut0 (
      .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2), .RD1(rd1_n), .RD2(rd2_n),
      .RegWrite(RegWrite), .WA(WA), .WD(WD)
   );

   always @(posedge reset) foreach (model[i]) model[i] = '0;
   always @(posedge clk)
      if (!reset && RegWrite === 1'b1 && !$isunknown(WA) && WA != 5'd31) model[WA] = WD;

   function automatic logic [63:0] exp_rd(input logic [4:0] ra, input bit byp);
      if (reset || ra == 5'd31) return '0;
      if (byp && RegWrite === 1'b1 && WA === ra) return WD;
      return model[ra];
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (chk_en) begin
         check("rd1_byp", rd1_b, exp_rd(RA1, 1'b1));
         check("rd2_byp", rd2_b, exp_rd(RA2, 1'b1));
         check("rd1_nobyp", rd1_n, exp_rd(RA1, 1'b0));
         check("rd2_nobyp", rd2_n, exp_rd(RA2, 1'b0));
      end

   task automatic edge_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [63:0] d);
      RegWrite = 1'b1;
      WA = a;
      WD = d;
      edge_tick();
      RegWrite = 1'b0;
   endtask

   initial begin
      foreach (model[i]) model[i] = '0;
      RA1 = 5'd5;
      #1;
      check("reset_rd1", rd1_b, 64'h0);
      check("reset_rd2", rd2_b, 64'h0);
      chk_en = 1'b1;
      edge_tick();
      edge_tick();
      reset = 1'b0;
      edge_tick();

      // async reset clears X5 before any clock edge
      wr(5'd5, 64'hDEAD);
      RA1 = 5'd5;
      #1;
      check("x5_written", rd1_b, 64'hDEAD);
      #1;
      reset = 1'b1;
      #1;
      check("x5_async_clear", rd1_b, 64'h0);
      check("x5_async_clear_nb", rd1_n, 64'h0);
      edge_tick();
      reset = 1'b0;
      edge_tick();

      wr(5'd3, 64'h0123_4567_89AB_CDEF);
      RA1 = 5'd3;
      RA2 = 5'd3;
      #1;
      check("x3_rd1", rd1_b, 64'h0123_4567_89AB_CDEF);
      check("x3_rd2", rd2_b, 64'h0123_4567_89AB_CDEF);

      RegWrite = 1'b1;
      WA = 5'd31;
      WD = '1;
      RA1 = 5'd31;
      #1;
      check("xzr_pre", rd1_b, 64'h0);
      check("xzr_pre_nb", rd1_n, 64'h0);
      edge_tick();
      RegWrite = 1'b0;
      #1;
      check("xzr_post", rd1_b, 64'h0);

      wr(5'd7, 64'h11);
      RegWrite = 1'b1;
      WA = 5'd7;
      WD = 64'h22;
      RA2 = 5'd7;
      #1;
      check("byp_pre", rd2_b, 64'h22);
      check("nobyp_pre", rd2_n, 64'h11);
      edge_tick();
      RegWrite = 1'b0;
      #1;
      check("byp_post", rd2_b, 64'h22);
      check("nobyp_post", rd2_n, 64'h22);

      RegWrite = 1'b0;
      WA = 5'd9;
      WD = 64'h55;
      RA1 = 5'd9;
      RA2 = 5'd3;
      repeat (3) edge_tick();
      check("x9_nowrite", rd1_b, 64'h0);
      WA = 'x;
      repeat (3) edge_tick();
      check("wax_x9", rd1_b, 64'h0);
      check("wax_x3", rd2_b, 64'h0123_4567_89AB_CDEF);
      RA2 = 5'd7;
      #1;
      check("wax_x7", rd2_n, 64'h22);

      for (int i = 0; i < 31; i++) wr(5'(i), 64'(i) * 64'h0101);
      for (int i = 0; i < 32; i++) begin
         logic [63:0] e;
         e = (i == 31) ? 64'h0 : 64'(i) * 64'h0101;
         RA1 = 5'(i);
         RA2 = 5'(31 - i);
         #1;
         check("walk_rd1", rd1_b, e);
         check("walk_rd1_nb", rd1_n, e);
         RA2 = 5'(i);
         #1;
         check("walk_rd2", rd2_b, e);
      end

      for (int n = 0; n < 2000; n++) begin
         edge_tick();
         reset = ($urandom_range(0, 59) == 0);
         RegWrite = 1'($urandom);
         WA = 5'($urandom);
         WD = {$urandom, $urandom};
         RA1 = ($urandom_range(0, 3) == 0) ? WA : 5'($urandom);
         RA2 = ($urandom_range(0, 3) == 0) ? RA1 : 5'($urandom);
      end
      edge_tick();
      reset = 1'b0;
      RegWrite = 1'b0;
      edge_tick();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
